// File: rtl/holl_buf_pkg.sv
// Shared register map, bit positions and prefetch FSM states for the
// slot-mapped stream buffer.
package holl_buf_pkg;

  localparam logic [4:0] REG_CTRL = 5'd0;
  localparam logic [4:0] REG_STAT = 5'd1;
  localparam logic [4:0] REG_PTR  = 5'd2;
  localparam logic [4:0] REG_DATA = 5'd3;

  localparam int CTRL_AUTO_INC = 0;
  localparam int CTRL_WRAP_EN  = 1;

  localparam int STAT_PF_VALID = 0;
  localparam int STAT_OVF      = 1;
  localparam int STAT_UNDERRUN = 2;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    CAPT  = 2'd1,
    VALID = 2'd2
  } pf_state_t;

endpackage

// File: rtl/sync_one_port_ram.sv
// Single-port synchronous RAM: one read-or-write address, read data
// appears one clock after the address is presented.
module sync_one_port_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= din;
    dout_q <= mem_q[addr];
  end

  assign dout = dout_q;

endmodule

// File: rtl/holl_stream_buf_core.sv
// MMIO slot front-end for a pointer-addressed RAM with a one-word prefetch
// buffer, sticky overflow/underrun flags and optional auto-increment.
module holl_stream_buf_core
  import holl_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_BITS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data
);

  logic [1:0]            ctrl_q, ctrl_d;
  logic [DEPTH_BITS-1:0] ptr_q, ptr_d;
  logic                  ovf_q, ovf_d;
  logic                  und_q, und_d;
  logic                  pfv_q, pfv_d;
  logic [DATA_WIDTH-1:0] pf_buf_q, pf_buf_d;
  pf_state_t             state_q, state_d;

  logic                  data_wr, data_rd, rd_pop, trigger;
  logic [DATA_WIDTH-1:0] ram_dout;

  // The RAM address is always PTR: a write and a fetch both target it.
  sync_one_port_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(DEPTH_BITS)
  ) u_ram (
    .clk (clk),
    .we  (data_wr),
    .addr(ptr_q),
    .din (wr_data[DATA_WIDTH-1:0]),
    .dout(ram_dout)
  );

  always_comb begin
    ctrl_d   = ctrl_q;
    ptr_d    = ptr_q;
    ovf_d    = ovf_q;
    und_d    = und_q;
    pfv_d    = pfv_q;
    pf_buf_d = pf_buf_q;
    state_d  = state_q;

    // A simultaneous read+write on DATA behaves as a pure write.
    data_wr = cs && write && (addr == REG_DATA);
    data_rd = cs && read && !write && (addr == REG_DATA);
    rd_pop  = data_rd && pfv_q;
    trigger = (cs && write && (addr == REG_PTR)) || data_wr ||
              (rd_pop && ctrl_q[CTRL_AUTO_INC]);

    if (cs && write && (addr == REG_CTRL)) ctrl_d = wr_data[1:0];

    // Clears are applied first so a same-cycle set overrides them.
    if (cs && write && (addr == REG_STAT)) begin
      if (wr_data[STAT_OVF])      ovf_d = 1'b0;
      if (wr_data[STAT_UNDERRUN]) und_d = 1'b0;
    end
    if (data_rd && !pfv_q) und_d = 1'b1;

    if (cs && write && (addr == REG_PTR)) begin
      ptr_d = wr_data[DEPTH_BITS-1:0];
    end else if (ctrl_q[CTRL_AUTO_INC] && (data_wr || rd_pop)) begin
      if (!(&ptr_q))                 ptr_d = ptr_q + 1'b1;
      else if (ctrl_q[CTRL_WRAP_EN]) ptr_d = '0;
      else                           ovf_d = 1'b1;
    end

    case (state_q)
      FETCH:   state_d = CAPT;
      CAPT: begin
        state_d  = VALID;
        pf_buf_d = ram_dout;
        pfv_d    = 1'b1;
      end
      default: state_d = VALID;
    endcase

    // A trigger restarts the fetch and suppresses any capture this cycle.
    if (trigger) begin
      state_d  = FETCH;
      pfv_d    = 1'b0;
      pf_buf_d = pf_buf_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q   <= '0;
      ptr_q    <= '0;
      ovf_q    <= 1'b0;
      und_q    <= 1'b0;
      pfv_q    <= 1'b0;
      pf_buf_q <= '0;
      state_q  <= FETCH;
    end else begin
      ctrl_q   <= ctrl_d;
      ptr_q    <= ptr_d;
      ovf_q    <= ovf_d;
      und_q    <= und_d;
      pfv_q    <= pfv_d;
      pf_buf_q <= pf_buf_d;
      state_q  <= state_d;
    end
  end

  always_comb begin
    rd_data = '0;
    if (cs && read) begin
      case (addr)
        REG_CTRL: rd_data = {30'b0, ctrl_q};
        REG_STAT: rd_data = {29'b0, und_q, ovf_q, pfv_q};
        REG_PTR:  rd_data = 32'(ptr_q);
        REG_DATA: rd_data = 32'(pf_buf_q);
        default:  rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_holl_stream_buf_core.sv
// Bench for holl_stream_buf_core: a wide/deep instance and a narrow/shallow
// instance on one clock, bus transactions driven on the falling edge.
module tb_holl_stream_buf_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cs = 1'b0, read = 1'b0, write = 1'b0;
  logic        sel = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd0, rd1, rd_data;
  logic        cs0, cs1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  assign cs0     = cs & ~sel;
  assign cs1     = cs & sel;
  assign rd_data = sel ? rd1 : rd0;

  always #5 clk = ~clk;

  holl_stream_buf_core #(.DATA_WIDTH(32), .DEPTH_BITS(10)) u_dut (
    .clk(clk), .reset(reset), .cs(cs0), .read(read), .write(write),
    .addr(addr), .wr_data(wr_data), .rd_data(rd0)
  );

  holl_stream_buf_core #(.DATA_WIDTH(8), .DEPTH_BITS(4)) u_dut_small (
    .clk(clk), .reset(reset), .cs(cs1), .read(read), .write(write),
    .addr(addr), .wr_data(wr_data), .rd_data(rd1)
  );

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; read = 1'b0; addr = a; wr_data = d;
    @(negedge clk);
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    cs = 1'b1; read = 1'b1; write = 1'b0; addr = a;
    #1 d = rd_data;
    @(negedge clk);
    cs = 1'b0; read = 1'b0;
  endtask

  task automatic bus_rdwr(input logic [4:0] a, input logic [31:0] wd,
                          output logic [31:0] d);
    cs = 1'b1; read = 1'b1; write = 1'b1; addr = a; wr_data = wd;
    #1 d = rd_data;
    @(negedge clk);
    cs = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    sel = 1'b0;
    reset = 1'b0; idle(2);
    reset = 1'b1; idle(2);
    bus_write(5'd3, 32'h5A5A_0001);
    reset = 1'b0; idle(1);
    reset = 1'b1; idle(2);
    exp_q.push_back(32'h5A5A_0001);
    bus_read(5'd1, v);
    n_checks++;
    if (v !== 32'h1) $display("FAIL reset_stat got=%h exp=%h", v, 32'h1); else n_pass++;
    bus_read(5'd2, v);
    n_checks++;
    if (v !== 32'h0) $display("FAIL reset_ptr got=%h exp=%h", v, 32'h0); else n_pass++;
    bus_read(5'd0, v);
    n_checks++;
    if (v !== 32'h0) $display("FAIL reset_ctrl got=%h exp=%h", v, 32'h0); else n_pass++;
    bus_read(5'd3, v);
    n_checks++;
    if (v !== exp_q[0]) $display("FAIL reset_data got=%h exp=%h", v, exp_q[0]); else n_pass++;
    void'(exp_q.pop_front());
    cs = 1'b0; read = 1'b0; addr = 5'd1;
    #1;
    n_checks++;
    if (rd_data !== 32'h0) $display("FAIL idle_rd_zero got=%h exp=0", rd_data); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_stream();
    logic [31:0] v, e;
    sel = 1'b0;
    bus_write(5'd0, 32'h1);
    bus_write(5'd2, 32'd5);
    for (int i = 0; i < 3; i++) begin
      bus_write(5'd3, 32'hA1 + i);
      exp_q.push_back(32'hA1 + i);
    end
    bus_read(5'd2, v);
    n_checks++;
    if (v !== 32'd8) $display("FAIL stream_ptr_after_wr got=%0d exp=8", v); else n_pass++;
    bus_write(5'd2, 32'd5);
    for (int i = 0; i < 3; i++) begin
      idle(2);
      bus_read(5'd3, v);
      e = exp_q.pop_front();
      n_checks++;
      if (v !== e) $display("FAIL stream_rd%0d got=%h exp=%h", i, v, e); else n_pass++;
    end
    bus_read(5'd2, v);
    n_checks++;
    if (v !== 32'd8) $display("FAIL stream_ptr_after_rd got=%0d exp=8", v); else n_pass++;
  endtask

  task automatic test_underrun();
    logic [31:0] v, e;
    sel = 1'b0;
    bus_write(5'd2, 32'd5);
    bus_read(5'd3, v);
    bus_read(5'd1, v);
    n_checks++;
    if (v !== 32'h4) $display("FAIL underrun_stat got=%h exp=%h", v, 32'h4); else n_pass++;
    bus_read(5'd2, v);
    n_checks++;
    if (v !== 32'd5) $display("FAIL underrun_ptr got=%0d exp=5", v); else n_pass++;
    bus_write(5'd1, 32'h4);
    bus_read(5'd1, v);
    n_checks++;
    if (v !== 32'h1) $display("FAIL underrun_clear got=%h exp=%h", v, 32'h1); else n_pass++;
    exp_q.push_back(32'hA1);
    bus_read(5'd3, v);
    e = exp_q.pop_front();
    n_checks++;
    if (v !== e) $display("FAIL underrun_reread got=%h exp=%h", v, e); else n_pass++;
  endtask

  task automatic test_wrap_small();
    logic [31:0] v, e;
    sel = 1'b1;
    bus_write(5'd0, 32'h3);
    bus_write(5'd2, 32'd15);
    bus_write(5'd3, 32'h11);
    bus_read(5'd2, v);
    n_checks++;
    if (v !== 32'd0) $display("FAIL wrap_ptr got=%0d exp=0", v); else n_pass++;
    bus_write(5'd0, 32'h1);
    bus_write(5'd2, 32'd15);
    bus_write(5'd3, 32'h22);
    bus_read(5'd1, v);
    n_checks++;
    if (v !== 32'h2) $display("FAIL ovf_stat got=%h exp=%h", v, 32'h2); else n_pass++;
    bus_read(5'd2, v);
    n_checks++;
    if (v !== 32'd15) $display("FAIL ovf_ptr got=%0d exp=15", v); else n_pass++;
    bus_write(5'd0, 32'h0);
    bus_write(5'd2, 32'd3);
    bus_write(5'd3, 32'h1234_56FF);
    exp_q.push_back(32'h0000_00FF);
    idle(2);
    bus_read(5'd3, v);
    e = exp_q.pop_front();
    n_checks++;
    if (v !== e) $display("FAIL narrow_data got=%h exp=%h", v, e); else n_pass++;
    sel = 1'b0;
  endtask

  task automatic test_write_restart();
    logic [31:0] v, e;
    sel = 1'b0;
    bus_write(5'd0, 32'h0);
    bus_write(5'd2, 32'd9);
    bus_write(5'd3, 32'hB5);
    exp_q.push_back(32'hB5);
    for (int i = 0; i < 2; i++) begin
      bus_read(5'd1, v);
      n_checks++;
      if (v !== 32'h0) $display("FAIL restart_pending%0d got=%h exp=0", i, v); else n_pass++;
    end
    bus_read(5'd1, v);
    n_checks++;
    if (v !== 32'h1) $display("FAIL restart_valid got=%h exp=%h", v, 32'h1); else n_pass++;
    bus_read(5'd3, v);
    e = exp_q.pop_front();
    n_checks++;
    if (v !== e) $display("FAIL restart_data got=%h exp=%h", v, e); else n_pass++;
    bus_rdwr(5'd3, 32'hC6, v);
    n_checks++;
    if (v !== 32'hB5) $display("FAIL rdwr_old got=%h exp=%h", v, 32'hB5); else n_pass++;
    exp_q.push_back(32'hC6);
    idle(2);
    bus_read(5'd3, v);
    e = exp_q.pop_front();
    n_checks++;
    if (v !== e) $display("FAIL rdwr_new got=%h exp=%h", v, e); else n_pass++;
  endtask

  task automatic test_reset_mid_fetch();
    logic [31:0] v, e;
    sel = 1'b0;
    bus_write(5'd0, 32'h3);
    bus_write(5'd2, 32'd5);
    idle(1);
    reset = 1'b0;
    cs = 1'b1; read = 1'b1;
    for (int a = 0; a < 3; a++) begin
      addr = 5'(a);
      #1;
      n_checks++;
      if (rd_data !== 32'h0) $display("FAIL reset_mid_reg%0d got=%h exp=0", a, rd_data); else n_pass++;
    end
    cs = 1'b0; read = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    idle(1);
    bus_write(5'd2, 32'd5);
    exp_q.push_back(32'hA1);
    idle(2);
    bus_read(5'd3, v);
    e = exp_q.pop_front();
    n_checks++;
    if (v !== e) $display("FAIL ram_retained got=%h exp=%h", v, e); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_underrun();
    test_wrap_small();
    test_write_restart();
    test_reset_mid_fetch();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
